// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory port arbiter.
// Contents:
//   DEF_ADDR_W / DEF_DATA_W / DEF_LEN_W : default word-address, data and burst-length widths
//   arb_state_e : arbiter FSM states
//   req_e       : requester identity, used for round-robin history and return routing
//   rd_tag_t    : per-read tag carried down the read-latency pipeline
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 30;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LEN_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        CPU_ACC,
        CPU_WAIT,
        GFX_ISSUE,
        GFX_DRAIN
    } arb_state_e;

    typedef enum logic {
        REQ_CPU,
        REQ_GFX
    } req_e;

    typedef struct packed {
        logic valid;
        req_e owner;
        logic last;
    } rd_tag_t;

endpackage

// File: rtl/rd_lat_pipe.sv
// Read-latency tag pipeline: a READ_LAT-deep shift register of {valid, owner, last}.
// A tag pushed in the cycle a read strobe is issued comes out exactly READ_LAT cycles
// later, lined up with the memory's returned data.
// Ports:
//   clk_i    : clock, rising edge
//   rst_n_i  : asynchronous active-low clear (drops every in-flight tag)
//   tag_in   : tag for the read issued this cycle (valid=0 when nothing is issued)
//   tag_out  : tag whose data is on the memory read bus this cycle
module rd_lat_pipe
    import mem_arb_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic    clk_i,
    input  logic    rst_n_i,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t stage_q [READ_LAT];

    // Plain shift register; stage 0 takes the new tag, every other stage takes its
    // predecessor. Reset clears all stages so no stale rvalid can appear after release.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < READ_LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < READ_LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_out = stage_q[READ_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sequencing arbiter sharing a single-port data memory between a CPU
// requester (single-word reads/writes) and a graphics fetch requester (read bursts).
// Ports:
//   clk_i, rst_n_i                 : clock and asynchronous active-low reset
//   cpu_req_i/we_i/addr_i/wdata_i  : CPU request, held until cpu_gnt_o
//   cpu_gnt_o, cpu_rvalid_o        : CPU handshake and read-return pulse
//   cpu_rdata_o                    : CPU read data, held until the next return
//   gfx_req_i/addr_i/len_i         : graphics burst request (length = len+1 words)
//   gfx_gnt_o, gfx_rvalid_o        : graphics handshake and per-word return pulse
//   gfx_rdata_o, gfx_last_o        : returned burst word and final-word marker
//   mem_MR_o, mem_MW_o             : memory read / write strobes
//   mem_address_o, mem_data_o      : memory word address and write data
//   mem_data_i                     : memory read data, READ_LAT cycles after mem_MR_o
// READ_LAT is legal in 1..4.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int READ_LAT = 1,
    parameter int LEN_W    = DEF_LEN_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    input  logic              gfx_req_i,
    input  logic [ADDR_W-1:0] gfx_addr_i,
    input  logic [LEN_W-1:0]  gfx_len_i,
    output logic              gfx_gnt_o,
    output logic              gfx_rvalid_o,
    output logic [DATA_W-1:0] gfx_rdata_o,
    output logic              gfx_last_o,
    output logic              mem_MR_o,
    output logic              mem_MW_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i
);

    arb_state_e        state_q, state_d;
    req_e              last_grant_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  k_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    rd_tag_t           issue_tag;
    rd_tag_t           ret_tag;

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and all strobe/grant outputs. Grants are combinational in IDLE and
    // are also held low while reset is asserted, since reset parks the FSM in IDLE
    // while requests may still be high. On a tie the requester that did not win last
    // time gets the grant.
    always_comb begin
        state_d       = state_q;
        cpu_gnt_o     = 1'b0;
        gfx_gnt_o     = 1'b0;
        mem_MR_o      = 1'b0;
        mem_MW_o      = 1'b0;
        mem_address_o = '0;
        mem_data_o    = '0;
        issue_tag     = '0;
        case (state_q)
            IDLE: begin
                if (rst_n_i) begin
                    if (cpu_req_i && (!gfx_req_i || last_grant_q == REQ_GFX)) begin
                        cpu_gnt_o = 1'b1;
                        state_d   = CPU_ACC;
                    end else if (gfx_req_i) begin
                        gfx_gnt_o = 1'b1;
                        state_d   = GFX_ISSUE;
                    end
                end
            end
            CPU_ACC: begin
                mem_address_o = addr_q;
                if (we_q) begin
                    mem_MW_o   = 1'b1;
                    mem_data_o = wdata_q;
                    state_d    = IDLE;
                end else begin
                    mem_MR_o  = 1'b1;
                    issue_tag = '{valid: 1'b1, owner: REQ_CPU, last: 1'b0};
                    state_d   = CPU_WAIT;
                end
            end
            CPU_WAIT: begin
                if (cpu_rvalid_o) begin
                    state_d = IDLE;
                end
            end
            GFX_ISSUE: begin
                mem_MR_o      = 1'b1;
                mem_address_o = addr_q;
                issue_tag     = '{valid: 1'b1, owner: REQ_GFX, last: (k_q == len_q)};
                if (k_q == len_q) begin
                    state_d = GFX_DRAIN;
                end
            end
            GFX_DRAIN: begin
                if (gfx_rvalid_o && gfx_last_o) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture on grant, and the burst address/word counters. The address
    // register simply rolls over at the top of the word-address space.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_grant_q <= REQ_GFX;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            len_q        <= '0;
            k_q          <= '0;
        end else if (cpu_gnt_o) begin
            last_grant_q <= REQ_CPU;
            we_q         <= cpu_we_i;
            addr_q       <= cpu_addr_i;
            wdata_q      <= cpu_wdata_i;
        end else if (gfx_gnt_o) begin
            last_grant_q <= REQ_GFX;
            addr_q       <= gfx_addr_i;
            len_q        <= gfx_len_i;
            k_q          <= '0;
        end else if (state_q == GFX_ISSUE) begin
            addr_q <= addr_q + 1'b1;
            k_q    <= k_q + 1'b1;
        end
    end

    // CPU read data is shown straight from the memory bus in its return cycle and
    // then held from this register until the next CPU return.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cpu_rdata_q <= '0;
        end else if (cpu_rvalid_o) begin
            cpu_rdata_q <= mem_data_i;
        end
    end

    rd_lat_pipe #(
        .READ_LAT (READ_LAT)
    ) u_rd_lat_pipe (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .tag_in  (issue_tag),
        .tag_out (ret_tag)
    );

    assign cpu_rvalid_o = ret_tag.valid && (ret_tag.owner == REQ_CPU);
    assign gfx_rvalid_o = ret_tag.valid && (ret_tag.owner == REQ_GFX);
    assign gfx_last_o   = gfx_rvalid_o && ret_tag.last;
    assign gfx_rdata_o  = gfx_rvalid_o ? mem_data_i : '0;
    assign cpu_rdata_o  = cpu_rvalid_o ? mem_data_i : cpu_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. One instance uses READ_LAT=1, a second
// uses READ_LAT=3; each has its own small memory model with the matching latency.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // READ_LAT=1 instance signals
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [29:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        gfx_req = 1'b0;
    logic [29:0] gfx_addr = '0;
    logic [3:0]  gfx_len = '0;
    logic        gfx_gnt, gfx_rvalid, gfx_last;
    logic [31:0] gfx_rdata;
    logic        mem_MR, mem_MW;
    logic [29:0] mem_address;
    logic [31:0] mem_data_out;
    logic [31:0] mem_rd_q = '0;

    // READ_LAT=3 instance signals
    logic        c3_req = 1'b0, c3_we = 1'b0;
    logic [29:0] c3_addr = '0;
    logic [31:0] c3_wdata = '0;
    logic        c3_gnt, c3_rvalid;
    logic [31:0] c3_rdata;
    logic        g3_req = 1'b0;
    logic [29:0] g3_addr = '0;
    logic [3:0]  g3_len = '0;
    logic        g3_gnt, g3_rvalid, g3_last;
    logic [31:0] g3_rdata;
    logic        m3_MR, m3_MW;
    logic [29:0] m3_address;
    logic [31:0] m3_data_out;
    logic [31:0] m3_d1 = '0, m3_d2 = '0, m3_d3 = '0;

    int total = 0;
    int bad = 0;

    mem_port_arbiter dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
        .gfx_req_i(gfx_req), .gfx_addr_i(gfx_addr), .gfx_len_i(gfx_len),
        .gfx_gnt_o(gfx_gnt), .gfx_rvalid_o(gfx_rvalid), .gfx_rdata_o(gfx_rdata), .gfx_last_o(gfx_last),
        .mem_MR_o(mem_MR), .mem_MW_o(mem_MW), .mem_address_o(mem_address),
        .mem_data_o(mem_data_out), .mem_data_i(mem_rd_q)
    );

    mem_port_arbiter #(.READ_LAT(3)) dut3 (
        .clk_i(clk), .rst_n_i(rst_n),
        .cpu_req_i(c3_req), .cpu_we_i(c3_we), .cpu_addr_i(c3_addr), .cpu_wdata_i(c3_wdata),
        .cpu_gnt_o(c3_gnt), .cpu_rvalid_o(c3_rvalid), .cpu_rdata_o(c3_rdata),
        .gfx_req_i(g3_req), .gfx_addr_i(g3_addr), .gfx_len_i(g3_len),
        .gfx_gnt_o(g3_gnt), .gfx_rvalid_o(g3_rvalid), .gfx_rdata_o(g3_rdata), .gfx_last_o(g3_last),
        .mem_MR_o(m3_MR), .mem_MW_o(m3_MW), .mem_address_o(m3_address),
        .mem_data_o(m3_data_out), .mem_data_i(m3_d3)
    );

    always #5 clk = ~clk;

    // Memory contents: one special word for the CPU read test, otherwise the word
    // address tagged with 2'b10 in the top bits.
    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return (a == 30'h3000FFFF) ? 32'hCCCCCCCC : {2'b10, a};
    endfunction

    // Memory models: data for a read strobe appears READ_LAT cycles later; when no
    // read was issued the bus carries filler so held values can be told apart.
    always @(posedge clk) begin
        mem_rd_q <= mem_MR ? mem_word(mem_address) : 32'hDEADBEEF;
        m3_d1    <= m3_MR ? mem_word(m3_address) : 32'hDEADBEEF;
        m3_d2    <= m3_d1;
        m3_d3    <= m3_d2;
    end

    // Advance to 2 time units after the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reset while requests are high, then reset in the middle of a 16-word burst;
    // nothing from the aborted burst may come back, and the first tie goes to CPU.
    task automatic test_reset();
        rst_n = 1'b0; cpu_req = 1'b1; gfx_req = 1'b1;
        #1;
        total++; if (cpu_gnt !== 1'b0) begin bad++; $display("[TB] FAIL rst_cpu_gnt got=%0h want=0", cpu_gnt); end
        total++; if (gfx_gnt !== 1'b0) begin bad++; $display("[TB] FAIL rst_gfx_gnt got=%0h want=0", gfx_gnt); end
        total++; if (mem_MR !== 1'b0 || mem_MW !== 1'b0) begin bad++; $display("[TB] FAIL rst_strobes got=%0h%0h want=00", mem_MR, mem_MW); end
        total++; if (cpu_rdata !== 32'h0 || gfx_rdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_rdata got=%0h/%0h want=0/0", cpu_rdata, gfx_rdata); end
        step();
        cpu_req = 1'b0; gfx_req = 1'b0; rst_n = 1'b1;
        step();
        gfx_req = 1'b1; gfx_addr = 30'h100; gfx_len = 4'd15;
        #1;
        total++; if (gfx_gnt !== 1'b1) begin bad++; $display("[TB] FAIL burst_gnt got=%0h want=1", gfx_gnt); end
        step();
        gfx_req = 1'b0;
        for (int i = 0; i < 5; i++) step();
        #1;
        total++; if (mem_MR !== 1'b1 || mem_address !== 30'h105) begin bad++; $display("[TB] FAIL k5_issue got=%0h/%0h want=1/105", mem_MR, mem_address); end
        total++; if (gfx_rvalid !== 1'b1 || gfx_rdata !== 32'h80000104) begin bad++; $display("[TB] FAIL k4_return got=%0h/%0h want=1/80000104", gfx_rvalid, gfx_rdata); end
        rst_n = 1'b0;
        #1;
        total++; if (mem_MR !== 1'b0 || mem_MW !== 1'b0) begin bad++; $display("[TB] FAIL midrst_strobes got=%0h%0h want=00", mem_MR, mem_MW); end
        total++; if (mem_address !== 30'h0 || mem_data_out !== 32'h0) begin bad++; $display("[TB] FAIL midrst_addr_data got=%0h/%0h want=0/0", mem_address, mem_data_out); end
        total++; if (gfx_rvalid !== 1'b0 || gfx_last !== 1'b0 || gfx_rdata !== 32'h0) begin bad++; $display("[TB] FAIL midrst_gfx_ret got=%0h/%0h/%0h want=0/0/0", gfx_rvalid, gfx_last, gfx_rdata); end
        total++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin bad++; $display("[TB] FAIL midrst_cpu_ret got=%0h/%0h want=0/0", cpu_rvalid, cpu_rdata); end
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            #1;
            total++; if (gfx_rvalid !== 1'b0 || mem_MR !== 1'b0) begin bad++; $display("[TB] FAIL post_rst_quiet c=%0d got=%0h/%0h want=0/0", c, gfx_rvalid, mem_MR); end
        end
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 30'h5; cpu_wdata = 32'h11;
        gfx_req = 1'b1; gfx_addr = 30'h40; gfx_len = 4'd0;
        #1;
        total++; if (cpu_gnt !== 1'b1 || gfx_gnt !== 1'b0) begin bad++; $display("[TB] FAIL first_tie got=%0h/%0h want=1/0", cpu_gnt, gfx_gnt); end
        step();
        cpu_req = 1'b0; gfx_req = 1'b0;
        step();
    endtask

    // Single CPU write: one access cycle with MW, no read strobe, no return pulse.
    task automatic test_cpu_write();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 30'h0000FFFF; cpu_wdata = 32'hF0F0F0F0;
        #1;
        total++; if (cpu_gnt !== 1'b1 || mem_MR !== 1'b0) begin bad++; $display("[TB] FAIL wr_gnt got=%0h/%0h want=1/0", cpu_gnt, mem_MR); end
        step();
        cpu_req = 1'b0;
        #1;
        total++; if (mem_MW !== 1'b1 || mem_MR !== 1'b0) begin bad++; $display("[TB] FAIL wr_strobes got=%0h%0h want=10", mem_MW, mem_MR); end
        total++; if (mem_address !== 30'h0000FFFF) begin bad++; $display("[TB] FAIL wr_addr got=%0h want=ffff", mem_address); end
        total++; if (mem_data_out !== 32'hF0F0F0F0) begin bad++; $display("[TB] FAIL wr_data got=%0h want=f0f0f0f0", mem_data_out); end
        total++; if (cpu_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL wr_rvalid1 got=%0h want=0", cpu_rvalid); end
        step();
        #1;
        total++; if (mem_MW !== 1'b0 || mem_MR !== 1'b0 || cpu_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL wr_after got=%0h/%0h/%0h want=0/0/0", mem_MW, mem_MR, cpu_rvalid); end
        step();
    endtask

    // Single CPU read with READ_LAT=1: strobe in cycle 1, data in cycle 2, then held.
    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 30'h3000FFFF;
        #1;
        total++; if (cpu_gnt !== 1'b1) begin bad++; $display("[TB] FAIL rd_gnt got=%0h want=1", cpu_gnt); end
        step();
        cpu_req = 1'b0;
        #1;
        total++; if (mem_MR !== 1'b1 || mem_MW !== 1'b0) begin bad++; $display("[TB] FAIL rd_strobes got=%0h%0h want=10", mem_MR, mem_MW); end
        total++; if (mem_address !== 30'h3000FFFF) begin bad++; $display("[TB] FAIL rd_addr got=%0h want=3000ffff", mem_address); end
        step();
        #1;
        total++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hCCCCCCCC) begin bad++; $display("[TB] FAIL rd_return got=%0h/%0h want=1/cccccccc", cpu_rvalid, cpu_rdata); end
        total++; if (mem_MR !== 1'b0) begin bad++; $display("[TB] FAIL rd_wait_mr got=%0h want=0", mem_MR); end
        step();
        #1;
        total++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'hCCCCCCCC) begin bad++; $display("[TB] FAIL rd_hold got=%0h/%0h want=0/cccccccc", cpu_rvalid, cpu_rdata); end
        step();
    endtask

    // Three-word burst crossing the top of the address space.
    task automatic test_gfx_wrap();
        logic [29:0] exp_a [3];
        logic [31:0] exp_d [3];
        exp_a = '{30'h3FFFFFFE, 30'h3FFFFFFF, 30'h00000000};
        exp_d = '{32'hBFFFFFFE, 32'hBFFFFFFF, 32'h80000000};
        gfx_req = 1'b1; gfx_addr = 30'h3FFFFFFE; gfx_len = 4'd2;
        #1;
        total++; if (gfx_gnt !== 1'b1) begin bad++; $display("[TB] FAIL wrap_gnt got=%0h want=1", gfx_gnt); end
        step();
        gfx_req = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            total++; if (mem_MR !== 1'(c <= 3)) begin bad++; $display("[TB] FAIL wrap_mr c=%0d got=%0h want=%0h", c, mem_MR, (c <= 3)); end
            if (c <= 3) begin
                total++; if (mem_address !== exp_a[c-1]) begin bad++; $display("[TB] FAIL wrap_addr c=%0d got=%0h want=%0h", c, mem_address, exp_a[c-1]); end
            end
            total++; if (gfx_rvalid !== 1'(c >= 2 && c <= 4)) begin bad++; $display("[TB] FAIL wrap_rvalid c=%0d got=%0h", c, gfx_rvalid); end
            total++; if (gfx_last !== 1'(c == 4)) begin bad++; $display("[TB] FAIL wrap_last c=%0d got=%0h want=%0h", c, gfx_last, (c == 4)); end
            if (c >= 2 && c <= 4) begin
                total++; if (gfx_rdata !== exp_d[c-2]) begin bad++; $display("[TB] FAIL wrap_data c=%0d got=%0h want=%0h", c, gfx_rdata, exp_d[c-2]); end
            end
            step();
        end
    endtask

    // Both requesters held high: CPU writes and one-word bursts must alternate,
    // with grants only ever in IDLE (cycles 0, 2, 5, 7, 10).
    task automatic test_round_robin();
        logic exp_c, exp_g;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 30'h77; cpu_wdata = 32'h12345678;
        gfx_req = 1'b1; gfx_addr = 30'h10; gfx_len = 4'd0;
        for (int c = 0; c <= 10; c++) begin
            exp_c = (c == 0 || c == 5 || c == 10);
            exp_g = (c == 2 || c == 7);
            #1;
            total++; if (cpu_gnt !== exp_c) begin bad++; $display("[TB] FAIL rr_cpu_gnt c=%0d got=%0h want=%0h", c, cpu_gnt, exp_c); end
            total++; if (gfx_gnt !== exp_g) begin bad++; $display("[TB] FAIL rr_gfx_gnt c=%0d got=%0h want=%0h", c, gfx_gnt, exp_g); end
            total++; if (mem_MR === 1'b1 && mem_MW === 1'b1) begin bad++; $display("[TB] FAIL rr_excl c=%0d got=11 want=not both", c); end
            if (c == 10) begin
                cpu_req = 1'b0; gfx_req = 1'b0;
            end
            step();
        end
        step();
    endtask

    // READ_LAT=3 instance: four-word burst, each return three cycles after its
    // strobe, and the FSM back in IDLE (CPU grantable) the cycle after the last word.
    task automatic test_lat3();
        logic [29:0] ea;
        for (int c = 0; c <= 8; c++) begin
            if (c == 0) begin
                g3_req = 1'b1; g3_addr = 30'h20; g3_len = 4'd3;
            end else begin
                g3_req = 1'b0;
            end
            if (c >= 5) begin
                c3_req = 1'b1; c3_we = 1'b1; c3_addr = 30'h0; c3_wdata = 32'h0;
            end
            #1;
            if (c == 0) begin
                total++; if (g3_gnt !== 1'b1) begin bad++; $display("[TB] FAIL l3_gnt got=%0h want=1", g3_gnt); end
            end
            total++; if (m3_MR !== 1'(c >= 1 && c <= 4)) begin bad++; $display("[TB] FAIL l3_mr c=%0d got=%0h", c, m3_MR); end
            if (c >= 1 && c <= 4) begin
                ea = 30'h20 + 30'(c - 1);
                total++; if (m3_address !== ea) begin bad++; $display("[TB] FAIL l3_addr c=%0d got=%0h want=%0h", c, m3_address, ea); end
            end
            total++; if (g3_rvalid !== 1'(c >= 4 && c <= 7)) begin bad++; $display("[TB] FAIL l3_rvalid c=%0d got=%0h", c, g3_rvalid); end
            total++; if (g3_last !== 1'(c == 7)) begin bad++; $display("[TB] FAIL l3_last c=%0d got=%0h", c, g3_last); end
            if (c >= 4 && c <= 7) begin
                ea = 30'h20 + 30'(c - 4);
                total++; if (g3_rdata !== {2'b10, ea}) begin bad++; $display("[TB] FAIL l3_data c=%0d got=%0h want=%0h", c, g3_rdata, {2'b10, ea}); end
            end
            total++; if (c3_gnt !== 1'(c == 8)) begin bad++; $display("[TB] FAIL l3_idle_gnt c=%0d got=%0h", c, c3_gnt); end
            if (c == 8) c3_req = 1'b0;
            step();
        end
        step();
    endtask

    // Run every scenario in order, then report.
    initial begin
        step();
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_gfx_wrap();
        test_round_robin();
        test_lat3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sequencing arbiter in the graphic controller that shares the single-port data memory between two requesters. The CPU requester makes single-word reads and writes. The graphics fetch requester makes read-only bursts.
Sits between the requesters and the memory side of the memory manager. It drives the word-addressed memory strobes, waits out the fixed memory read latency and routes returned data to the requester that issued the read.
Arbitration is round-robin at transaction boundaries, so neither requester can starve the other for more than one transaction.

Parameters:
ADDR_W, 30, word-address width (byte address bits [31:2]).
DATA_W, 32, data width.
READ_LAT, 1, cycles from mem_MR_o high to valid mem_data_i; legal range 1..4.
LEN_W, 4, graphics burst length field width; burst length = gfx_len_i+1, so 1..16 words at default.

Ports:
clk_i  in  1  single clock, all logic on rising edge.
rst_n_i  in  1  asynchronous, active-low reset.
cpu_req_i  in  1  CPU request valid; held with its fields until granted.
cpu_we_i  in  1  1 = write, 0 = read.
cpu_addr_i  in  ADDR_W  CPU word address.
cpu_wdata_i  in  DATA_W  CPU write data.
cpu_gnt_o  out  1  CPU request accepted this cycle (req & gnt = handshake).
cpu_rvalid_o  out  1  one-cycle pulse, cpu_rdata_o valid.
cpu_rdata_o  out  DATA_W  CPU read data, held until next cpu_rvalid_o.
gfx_req_i  in  1  graphics burst request valid.
gfx_addr_i  in  ADDR_W  burst start word address.
gfx_len_i  in  LEN_W  burst length minus one.
gfx_gnt_o  out  1  graphics request accepted this cycle.
gfx_rvalid_o  out  1  one pulse per returned burst word.
gfx_rdata_o  out  DATA_W  burst word data, valid with gfx_rvalid_o.
gfx_last_o  out  1  asserted with gfx_rvalid_o on the final word.
mem_MR_o  out  1  memory read strobe.
mem_MW_o  out  1  memory write strobe.
mem_address_o  out  ADDR_W  memory word address.
mem_data_o  out  DATA_W  memory write data.
mem_data_i  in  DATA_W  memory read data, READ_LAT cycles after mem_MR_o.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, last_grant=GFX.
  - All strobes, gnt, rvalid and last outputs are 0.
  - mem_address_o, mem_data_o, cpu_rdata_o and gfx_rdata_o are 0.
  - The in-flight read pipeline is cleared; no rvalid appears after release for reads issued before reset.
- IDLE:
  - mem strobes 0, mem_address_o/mem_data_o 0.
  - gnt outputs are combinational from state and requests; at most one is high.
  - Only one requester: grant it.
  - Both requesting: grant the one not equal to last_grant.
  - On grant, capture the request fields, update last_grant, and move to CPU_ACC or GFX_ISSUE.
- CPU_ACC (1 cycle):
  - Drives mem_address_o=captured addr and mem_MW_o=we or mem_MR_o=!we.
  - mem_data_o=captured wdata on a write.
  - Write: complete, return to IDLE; no cpu_rvalid_o.
  - Read: go to CPU_WAIT.
- CPU_WAIT:
  - Strobes 0.
  - READ_LAT cycles after the CPU_ACC cycle, cpu_rvalid_o=1 and cpu_rdata_o=mem_data_i (captured), then IDLE.
  - With READ_LAT=1 this is one cycle, so a CPU read occupies gnt, ACC and WAIT: 3 cycles.
- GFX_ISSUE:
  - mem_MR_o=1 every cycle with mem_address_o = start + k, k = 0..len.
  - Address increments modulo 2^ADDR_W (0x3FFFFFFF wraps to 0).
  - After the issue with k=len, go to GFX_DRAIN.
- GFX_DRAIN:
  - Strobes 0; wait until the last issued word returns, then IDLE.
- Return routing:
  - A READ_LAT-deep valid/last shift pipeline tags each issued read.
  - gfx_rvalid_o fires exactly READ_LAT cycles after each graphics issue cycle, with gfx_rdata_o=mem_data_i.
  - gfx_last_o accompanies the word issued at k=len.
- Requester ownership:
  - A requester must not be granted again until its transaction has fully completed, i.e. the FSM is back in IDLE.
  - Requests arriving mid-transaction wait; req may stay high.
- Write/read exclusivity: mem_MR_o and mem_MW_o are never high simultaneously.
- Back-to-back throughput:
  - CPU write gnt-to-gnt: 2 cycles.
  - Graphics burst of N words: N+READ_LAT+1 cycles gnt-to-IDLE.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, CPU_ACC, CPU_WAIT, GFX_ISSUE, GFX_DRAIN}.
  - Requester enum {REQ_CPU, REQ_GFX}.
  - Default width constants ADDR_W/DATA_W/LEN_W.
- One sub-module, rd_lat_pipe: a parameterised READ_LAT-deep shift register of {valid, owner, last} with async active-low clear. It generates the rvalid/last timing for both requesters.

Test Plan:
1. Reset mid-GFX_ISSUE (burst len enc 15, reset at k=5) -> all outputs 0 same cycle; after release no gfx_rvalid_o; first simultaneous request is granted to CPU.
2. CPU write addr 0x0000FFFF data 0xF0F0F0F0 -> cpu_gnt_o cycle 0. Cycle 1: mem_MW_o=1, mem_address_o=0x0000FFFF, mem_data_o=0xF0F0F0F0. mem_MR_o never high; cpu_rvalid_o never high.
3. CPU read addr 0x3000FFFF, memory model returns 0xCCCCCCCC (READ_LAT=1) -> mem_MR_o in cycle 1; cpu_rvalid_o=1 with cpu_rdata_o=0xCCCCCCCC in cycle 2; cpu_rdata_o held afterwards.
4. Graphics burst addr 0x3FFFFFFE, gfx_len_i=2 -> issued addresses 0x3FFFFFFE, 0x3FFFFFFF, 0x00000000 on consecutive cycles. gfx_rvalid_o on 3 consecutive cycles one later, gfx_last_o only on the third.
5. cpu_req_i and gfx_req_i held high continuously from reset -> grant order CPU, GFX, CPU, GFX. Never two gnts in one cycle; no gnt outside IDLE.
6. READ_LAT=3 build, graphics burst of 4 words -> each gfx_rvalid_o exactly 3 cycles after its mem_MR_o cycle; FSM returns to IDLE one cycle after gfx_last_o.
